// File: rtl/station_reader.sv
// ---------------------------------------------------------------------------
// station_reader
//
// Drain side of the P-WQE station buffer. Picks a filled, not-yet-issued slot
// in round-robin order, reads its P-WQE through buffer port 1 and hands it to
// ib_transport on a valid/ready handshake. Issued slots stay marked in flight
// until ib_transport releases them through the slot reset request.
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_slot_status  : filled-slot bitmap from the station buffer
//   o_ren/o_wen    : buffer port-1 read/write enables (write tied low)
//   o_addr, o_din  : buffer port-1 address and write data (data tied low)
//   i_dout         : buffer port-1 read data, valid one cycle after o_ren
//   o_pwqe_valid   : P-WQE presented to ib_transport
//   o_pwqe_data    : P-WQE payload
//   o_pwqe_slot    : slot the P-WQE came from
//   i_pwqe_ready   : ib_transport accepts the P-WQE
//   i_reset_req    : slot release request (snooped from the buffer interface)
//   i_reset_addr   : slot being released
//   o_busy         : FSM is outside IDLE
// ---------------------------------------------------------------------------
module station_reader #(
    parameter int PWQE_BUF_ADDR_WIDTH  = 2,
    parameter int PWQE_BUF_WIDTH       = 512,
    parameter int PWQE_SLOT_NUM        = 4,
    parameter int PWQE_SLOT_ADDR_WIDTH = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [PWQE_SLOT_NUM-1:0]        i_slot_status,
    output logic                            o_ren,
    output logic                            o_wen,
    output logic [PWQE_BUF_ADDR_WIDTH-1:0]  o_addr,
    output logic [PWQE_BUF_WIDTH-1:0]       o_din,
    input  logic [PWQE_BUF_WIDTH-1:0]       i_dout,
    output logic                            o_pwqe_valid,
    output logic [PWQE_BUF_WIDTH-1:0]       o_pwqe_data,
    output logic [PWQE_SLOT_ADDR_WIDTH-1:0] o_pwqe_slot,
    input  logic                            i_pwqe_ready,
    input  logic                            i_reset_req,
    input  logic [PWQE_SLOT_ADDR_WIDTH-1:0] i_reset_addr,
    output logic                            o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t                            state;
    logic [PWQE_SLOT_NUM-1:0]          inflight;
    logic [PWQE_SLOT_NUM-1:0]          rel;
    logic [PWQE_SLOT_NUM-1:0]          elig;
    logic [PWQE_SLOT_NUM-1:0]          set_mask;
    logic [PWQE_SLOT_ADDR_WIDTH-1:0]   rr_ptr;
    logic [PWQE_SLOT_ADDR_WIDTH-1:0]   sel;
    logic [PWQE_SLOT_ADDR_WIDTH-1:0]   grant_idx;
    logic [PWQE_SLOT_ADDR_WIDTH-1:0]   scan_idx;
    logic                              grant_found;
    logic                              grant;

    // Port 1 is read-only from this side.
    assign o_wen = 1'b0;
    assign o_din = '0;

    // A slot being released this cycle must not be granted, so the release
    // one-hot is masked out of eligibility.
    always_comb begin
        rel = '0;
        if (i_reset_req) begin
            rel[i_reset_addr] = 1'b1;
        end
    end

    assign elig = i_slot_status & ~inflight & ~rel;

    // Round-robin scan starting at rr_ptr; the index add wraps naturally
    // because the slot count is a power of two.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int i = 0; i < PWQE_SLOT_NUM; i++) begin
            scan_idx = rr_ptr + PWQE_SLOT_ADDR_WIDTH'(i);
            if (!grant_found && elig[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    assign grant = (state == IDLE) && grant_found;

    always_comb begin
        set_mask = '0;
        if (grant) begin
            set_mask[grant_idx] = 1'b1;
        end
    end

    // In-flight tracking: releases clear in any FSM state; set and clear never
    // collide because released slots are excluded from eligibility.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            inflight <= (inflight & ~rel) | set_mask;
        end
    end

    // Main FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            sel          <= '0;
            o_ren        <= 1'b0;
            o_addr       <= '0;
            o_pwqe_valid <= 1'b0;
            o_pwqe_data  <= '0;
            o_pwqe_slot  <= '0;
            o_busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        sel    <= grant_idx;
                        o_addr <= PWQE_BUF_ADDR_WIDTH'(grant_idx);
                        o_ren  <= 1'b1;
                        o_busy <= 1'b1;
                        rr_ptr <= grant_idx + PWQE_SLOT_ADDR_WIDTH'(1);
                        state  <= RD;
                    end
                end
                RD: begin
                    o_ren <= 1'b0;
                    state <= CAP;
                end
                CAP: begin
                    o_pwqe_data  <= i_dout;
                    o_pwqe_slot  <= sel;
                    o_pwqe_valid <= 1'b1;
                    state        <= OUT;
                end
                OUT: begin
                    if (i_pwqe_ready) begin
                        o_pwqe_valid <= 1'b0;
                        o_busy       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_station_reader.sv
// ---------------------------------------------------------------------------
// tb_station_reader
//
// Directed self-checking bench for station_reader. A small behavioural
// buffer returns mem[o_addr] one cycle after o_ren. Inputs change and outputs
// are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_station_reader;

    localparam int W = 512;

    logic           clk;
    logic           rst_n;
    logic [3:0]     slot_status;
    logic           ren;
    logic           wen;
    logic [1:0]     addr;
    logic [W-1:0]   din;
    logic [W-1:0]   dout;
    logic           pwqe_valid;
    logic [W-1:0]   pwqe_data;
    logic [1:0]     pwqe_slot;
    logic           pwqe_ready;
    logic           reset_req;
    logic [1:0]     reset_addr;
    logic           busy;

    logic [W-1:0]   mem [4];

    int checkCount;
    int failCount;

    station_reader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_slot_status (slot_status),
        .o_ren         (ren),
        .o_wen         (wen),
        .o_addr        (addr),
        .o_din         (din),
        .i_dout        (dout),
        .o_pwqe_valid  (pwqe_valid),
        .o_pwqe_data   (pwqe_data),
        .o_pwqe_slot   (pwqe_slot),
        .i_pwqe_ready  (pwqe_ready),
        .i_reset_req   (reset_req),
        .i_reset_addr  (reset_addr),
        .o_busy        (busy)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural buffer port 1: registered read, one cycle latency.
    always @(posedge clk) begin
        if (ren) begin
            dout <= mem[addr];
        end
    end

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive all handshake and status inputs at once.
    task automatic applyStimulus(input logic [3:0] status, input logic ready,
                                 input logic req, input logic [1:0] raddr);
        slot_status = status;
        pwqe_ready  = ready;
        reset_req   = req;
        reset_addr  = raddr;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges with idle inputs.
    task automatic applyReset();
        rst_n = 1'b0;
        applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        dout       = '0;
        for (int k = 0; k < 4; k++) begin
            mem[k] = {16{32'hC0DE_0000 + 32'(k * 17 + 3)}};
        end

        // Reset values.
        rst_n = 1'b0;
        applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0);
        tick();
        tick();
        checkOutput("rst_valid", W'(pwqe_valid), W'(0));
        checkOutput("rst_ren",   W'(ren),        W'(0));
        checkOutput("rst_busy",  W'(busy),       W'(0));
        checkOutput("rst_wen",   W'(wen),        W'(0));
        checkOutput("rst_din",   din,            W'(0));
        checkOutput("rst_addr",  W'(addr),       W'(0));
        checkOutput("rst_data",  pwqe_data,      W'(0));
        checkOutput("rst_slot",  W'(pwqe_slot),  W'(0));
        rst_n = 1'b1;

        // Single slot 2, ready held high.
        applyStimulus(4'b0100, 1'b1, 1'b0, 2'd0);
        tick();
        checkOutput("t1_ren",   W'(ren),  W'(1));
        checkOutput("t1_addr",  W'(addr), W'(2));
        checkOutput("t1_busy",  W'(busy), W'(1));
        tick();
        checkOutput("t1_ren_off",  W'(ren),        W'(0));
        checkOutput("t1_valid_lo", W'(pwqe_valid), W'(0));
        tick();
        checkOutput("t1_valid", W'(pwqe_valid), W'(1));
        checkOutput("t1_data",  pwqe_data,      mem[2]);
        checkOutput("t1_slot",  W'(pwqe_slot),  W'(2));
        tick();
        checkOutput("t1_valid_done", W'(pwqe_valid), W'(0));
        checkOutput("t1_busy_done",  W'(busy),       W'(0));
        tick();
        checkOutput("t1_no_regrant", W'(ren),           W'(0));
        checkOutput("t1_inflight",   W'(dut.inflight),  W'(4'b0100));
        applyStimulus(4'b0000, 1'b1, 1'b1, 2'd2);
        tick();
        applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0);
        checkOutput("t1_released", W'(dut.inflight), W'(4'b0000));

        // Slot 0 with ready held low for five cycles in OUT.
        applyStimulus(4'b0001, 1'b0, 1'b0, 2'd0);
        tick();
        checkOutput("t2_ren",  W'(ren),  W'(1));
        checkOutput("t2_addr", W'(addr), W'(0));
        tick();
        tick();
        checkOutput("t2_valid", W'(pwqe_valid), W'(1));
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("t2_hold_valid", W'(pwqe_valid), W'(1));
            checkOutput("t2_hold_data",  pwqe_data,      mem[0]);
            checkOutput("t2_hold_slot",  W'(pwqe_slot),  W'(0));
            checkOutput("t2_hold_ren",   W'(ren),        W'(0));
        end
        applyStimulus(4'b0001, 1'b1, 1'b0, 2'd0);
        tick();
        checkOutput("t2_accept_valid", W'(pwqe_valid), W'(0));
        checkOutput("t2_accept_busy",  W'(busy),       W'(0));
        applyStimulus(4'b0000, 1'b0, 1'b1, 2'd0);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0);
        checkOutput("t2_released", W'(dut.inflight), W'(4'b0000));

        // All slots full: issued 0,1,2,3 at four-cycle spacing.
        applyReset();
        applyStimulus(4'b1111, 1'b1, 1'b0, 2'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("t3_ren",  W'(ren),  W'(1));
            checkOutput("t3_addr", W'(addr), W'(k));
            tick();
            tick();
            checkOutput("t3_valid", W'(pwqe_valid), W'(1));
            checkOutput("t3_slot",  W'(pwqe_slot),  W'(k));
            checkOutput("t3_data",  pwqe_data,      mem[k]);
            tick();
            checkOutput("t3_accept", W'(pwqe_valid), W'(0));
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("t3_stall_ren",  W'(ren),  W'(0));
            checkOutput("t3_stall_busy", W'(busy), W'(0));
        end
        checkOutput("t3_inflight", W'(dut.inflight), W'(4'b1111));

        // Release slot 1, then refill it: re-issued once, pointer moves to 2.
        applyStimulus(4'b1101, 1'b1, 1'b1, 2'd1);
        tick();
        applyStimulus(4'b1101, 1'b1, 1'b0, 2'd0);
        checkOutput("t4_inflight_clr", W'(dut.inflight), W'(4'b1101));
        checkOutput("t4_no_ren",       W'(ren),          W'(0));
        tick();
        checkOutput("t4_empty_no_ren", W'(ren), W'(0));
        applyStimulus(4'b1111, 1'b1, 1'b0, 2'd0);
        tick();
        checkOutput("t4_ren",    W'(ren),        W'(1));
        checkOutput("t4_addr",   W'(addr),       W'(1));
        checkOutput("t4_rr_ptr", W'(dut.rr_ptr), W'(2));
        tick();
        tick();
        checkOutput("t4_valid", W'(pwqe_valid), W'(1));
        checkOutput("t4_slot",  W'(pwqe_slot),  W'(1));
        checkOutput("t4_data",  pwqe_data,      mem[1]);
        tick();
        checkOutput("t4_accept", W'(pwqe_valid), W'(0));
        for (int c = 0; c < 2; c++) begin
            tick();
            checkOutput("t4_once_ren", W'(ren), W'(0));
        end
        checkOutput("t4_inflight", W'(dut.inflight), W'(4'b1111));

        // Release and status for the same slot in one IDLE cycle: no grant.
        applyReset();
        applyStimulus(4'b0001, 1'b1, 1'b1, 2'd0);
        tick();
        checkOutput("t5_no_ren",   W'(ren),          W'(0));
        checkOutput("t5_no_busy",  W'(busy),         W'(0));
        checkOutput("t5_inflight", W'(dut.inflight), W'(4'b0000));
        applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0);
        tick();
        checkOutput("t5_cleared_no_ren", W'(ren), W'(0));
        applyStimulus(4'b0001, 1'b1, 1'b0, 2'd0);
        tick();
        checkOutput("t5_refill_ren",  W'(ren),  W'(1));
        checkOutput("t5_refill_addr", W'(addr), W'(0));
        tick();
        tick();
        checkOutput("t5_valid", W'(pwqe_valid), W'(1));
        checkOutput("t5_slot",  W'(pwqe_slot),  W'(0));
        tick();
        checkOutput("t5_accept", W'(pwqe_valid), W'(0));

        // Asynchronous reset while holding a P-WQE in OUT.
        applyReset();
        applyStimulus(4'b0001, 1'b0, 1'b0, 2'd0);
        tick();
        checkOutput("t6_ren", W'(ren), W'(1));
        tick();
        tick();
        checkOutput("t6_valid", W'(pwqe_valid), W'(1));
        applyStimulus(4'b0011, 1'b0, 1'b0, 2'd0);
        tick();
        checkOutput("t6_hold", W'(pwqe_valid), W'(1));
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_valid",    W'(pwqe_valid),   W'(0));
        checkOutput("t6_async_busy",     W'(busy),         W'(0));
        checkOutput("t6_async_inflight", W'(dut.inflight), W'(4'b0000));
        checkOutput("t6_async_rr_ptr",   W'(dut.rr_ptr),   W'(0));
        checkOutput("t6_async_data",     pwqe_data,        W'(0));
        #1;
        rst_n = 1'b1;
        tick();
        checkOutput("t6_rearb_ren",  W'(ren),  W'(1));
        checkOutput("t6_rearb_addr", W'(addr), W'(0));
        tick();
        tick();
        checkOutput("t6_rearb_slot", W'(pwqe_slot), W'(0));
        checkOutput("t6_rearb_data", pwqe_data,     mem[0]);
        applyStimulus(4'b0011, 1'b1, 1'b0, 2'd0);
        tick();
        checkOutput("t6_accept", W'(pwqe_valid), W'(0));
        tick();
        checkOutput("t6_next_addr", W'(addr), W'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
